// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram
//   Word-addressed Avalon-MM responder for CPU test benches. It stores
//   2^ADDR_BITS 32-bit words and inserts WAIT_STATES extra waitrequest
//   cycles per transfer. Writes update only the enabled byte lanes. A
//   preload port lets a bench write words directly into memory.
//
// Parameters
//   ADDR_BITS    word-index width (memory depth = 2^ADDR_BITS words)
//   WAIT_STATES  extra waitrequest-high cycles per transfer (0..15)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   address               byte address; [1:0] and bits above ADDR_BITS+1 ignored
//   read, write           transfer requests; both high is treated as a write
//   writedata, byteenable write word and its lane enables
//   waitrequest           low only in the cycle a transfer completes
//   readdata              read word, valid only in the completing cycle, else 0
//   load_en/addr/data     preload port; writes a full word at the edge
//   protocol_err          sticky flag: read and write were seen high together
module avalon_wait_ram #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        protocol_err
);

  localparam int          DEPTH    = 1 << ADDR_BITS;
  // Counter value at which BUSY hands over to ACK.
  localparam logic [3:0]  CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               waitrequest_q, waitrequest_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               protocol_err_q, protocol_err_d;
  logic               mem_we;
  logic               req;

  logic [31:0]        mem [DEPTH];

  logic [ADDR_BITS-1:0] bus_idx;
  logic [ADDR_BITS-1:0] load_idx;

  // Bits outside the word index are ignored, which makes addresses alias.
  assign bus_idx  = address[ADDR_BITS+1:2];
  assign load_idx = load_addr[ADDR_BITS+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_BITS+2], address[1:0],
                              load_addr[31:ADDR_BITS+2], load_addr[1:0]};

  assign req = read | write;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    readdata_d     = '0;
    protocol_err_d = protocol_err_q | (read & write);
    mem_we         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES == 0) ? S_ACK : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        // A request that dropped during ACK completes with no memory effect.
        mem_we  = req & write;
      end
      default: state_d = S_IDLE;
    endcase

    // readdata is captured on entry to ACK, so a preload at that same edge
    // is not visible in it. A simultaneous read+write is a write, so no data.
    if (state_d == S_ACK && !write) begin
      readdata_d = mem[bus_idx];
    end

    // waitrequest is a register decoded from the next state only.
    waitrequest_d = (state_d != S_ACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      waitrequest_q  <= 1'b1;
      readdata_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      waitrequest_q  <= waitrequest_d;
      readdata_q     <= readdata_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Memory is not reset. Preloads work during reset. A same-index preload
  // is written last, so it overrides a completing bus write entirely.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (byteenable[lane]) begin
          mem[bus_idx][8*lane +: 8] <= writedata[8*lane +: 8];
        end
      end
    end
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  assign waitrequest  = waitrequest_q;
  assign readdata     = readdata_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// tb_avalon_wait_ram
//   Bench for avalon_wait_ram. It uses two instances: dut1 has one wait
//   state, and dut0 has none and is used for held back-to-back reads. Both
//   share the preload port. Expected read words are queued when a read is
//   issued. A monitor per instance pops a word whenever that instance
//   completes a read, then compares it with readdata.
module tb_avalon_wait_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  logic [31:0] address1, writedata1, rdata1;
  logic        read1, write1, waitreq1, perr1;
  logic [3:0]  be1;

  logic [31:0] address0, writedata0, rdata0;
  logic        read0, write0, waitreq0, perr0;
  logic [3:0]  be0;

  avalon_wait_ram #(.ADDR_BITS(10), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .address(address1), .read(read1), .write(write1),
    .writedata(writedata1), .byteenable(be1), .waitrequest(waitreq1),
    .readdata(rdata1), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .protocol_err(perr1));

  avalon_wait_ram #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .address(address0), .read(read0), .write(write0),
    .writedata(writedata0), .byteenable(be0), .waitrequest(waitreq0),
    .readdata(rdata0), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .protocol_err(perr0));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] exp1, exp0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors: a read completes in a cycle where waitrequest is low.
  always @(negedge clk) begin
    if (!reset && waitreq1 === 1'b0 && read1 && !write1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd1_unexpected actual=%h expected=none", rdata1);
      end else begin
        exp1 = q1.pop_front();
        chk("rd1_data", rdata1, exp1);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && waitreq0 === 1'b0 && read0 && !write0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd0_unexpected actual=%h expected=none", rdata0);
      end else begin
        exp0 = q0.pop_front();
        chk("rd0_data", rdata0, exp0);
      end
    end
  end

  // Run one transfer on dut1. Optionally preload pl_data to the same address
  // at the completing edge. waits returns the waitrequest-high cycles seen.
  task automatic xfer1(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp, input logic pl,
                       input logic [31:0] pl_data, output int waits);
    @(posedge clk); #1;
    address1 = a; writedata1 = d; be1 = be; read1 = r; write1 = w;
    waits = 0;
    if (r && !w) q1.push_back(exp);
    while (1) begin
      @(negedge clk);
      if (waitreq1 === 1'b0) break;
      waits++;
      if (waits > 40) begin
        checks++; errors++;
        $display("FAIL xfer1_timeout actual=%0d expected=<=40", waits);
        break;
      end
    end
    if (pl) begin
      load_en = 1'b1; load_addr = a; load_data = pl_data;
    end
    @(posedge clk); #1;
    read1 = 1'b0; write1 = 1'b0; load_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          n;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];
    b2b_addr[0] = 32'h04; b2b_addr[1] = 32'h08; b2b_addr[2] = 32'h04;
    b2b_exp[0]  = 32'h24020010; b2b_exp[1] = 32'h24030100; b2b_exp[2] = 32'h24020010;

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    address1 = '0; writedata1 = '0; read1 = 1'b0; write1 = 1'b0; be1 = 4'hF;
    address0 = '0; writedata0 = '0; read0 = 1'b0; write0 = 1'b0; be0 = 4'hF;

    // Preload while reset is held.
    repeat (2) @(posedge clk);
    #1; load_en = 1'b1; load_addr = 32'h04; load_data = 32'h24020010;
    @(posedge clk); #1; load_addr = 32'h08; load_data = 32'h24030100;
    @(posedge clk); #1; load_en = 1'b0;
    @(negedge clk);
    chk("rst_waitreq1", {31'd0, waitreq1}, 32'd1);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_perr1", {31'd0, perr1}, 32'd0);
    chk("rst_waitreq0", {31'd0, waitreq0}, 32'd1);
    @(posedge clk); #1; reset = 1'b0;

    // Zero wait states with read held: ACK every second cycle.
    @(posedge clk); #1;
    address0 = b2b_addr[0]; read0 = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(b2b_exp[i]);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (1) begin
        @(negedge clk);
        n++;
        if (waitreq0 === 1'b0 || n > 20) break;
      end
      chk("b2b_period", 32'(n), 32'd2);
      @(posedge clk); #1;
      if (i < 2) address0 = b2b_addr[i+1];
      else read0 = 1'b0;
    end

    // Preloaded word with one wait state: waitrequest high for 2 cycles.
    xfer1(1'b1, 1'b0, 32'h04, '0, 4'hF, 32'h24020010, 1'b0, '0, w);
    chk("rd_wait_cycles", 32'(w), 32'd2);
    @(negedge clk);
    chk("rdata_idle_zero", rdata1, 32'd0);
    chk("waitreq_idle_high", {31'd0, waitreq1}, 32'd1);

    // Byte-lane writes.
    xfer1(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b1111, '0, 1'b0, '0, w);
    chk("wr_wait_cycles", 32'(w), 32'd2);
    xfer1(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, '0, 1'b0, '0, w);
    xfer1(1'b1, 1'b0, 32'h10, '0, 4'hF, 32'hAA22CC44, 1'b0, '0, w);

    // Aliasing through ignored address bits.
    xfer1(1'b1, 1'b0, 32'h1004, '0, 4'hF, 32'h24020010, 1'b0, '0, w);
    xfer1(1'b1, 1'b0, 32'h06, '0, 4'hF, 32'h24020010, 1'b0, '0, w);

    // Write dropped in BUSY has no effect.
    @(posedge clk); #1;
    address1 = 32'h10; writedata1 = 32'hDEADBEEF; be1 = 4'hF; write1 = 1'b1;
    @(posedge clk); #1; write1 = 1'b0;
    xfer1(1'b1, 1'b0, 32'h10, '0, 4'hF, 32'hAA22CC44, 1'b0, '0, w);

    // Reset in BUSY abandons the write.
    @(posedge clk); #1;
    address1 = 32'h10; writedata1 = 32'hDEADBEEF; be1 = 4'hF; write1 = 1'b1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy_waitreq", {31'd0, waitreq1}, 32'd1);
    write1 = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    xfer1(1'b1, 1'b0, 32'h10, '0, 4'hF, 32'hAA22CC44, 1'b0, '0, w);

    // read+write together acts as a write and sets protocol_err.
    xfer1(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, '0, 1'b0, '0, w);
    chk("perr_set", {31'd0, perr1}, 32'd1);
    xfer1(1'b1, 1'b0, 32'h20, '0, 4'hF, 32'h5, 1'b0, '0, w);
    // A same-index preload at the completing edge wins.
    xfer1(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, '0, 1'b1, 32'h7, w);
    xfer1(1'b1, 1'b0, 32'h20, '0, 4'hF, 32'h7, 1'b0, '0, w);
    chk("perr_sticky", {31'd0, perr1}, 32'd1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("perr_cleared", {31'd0, perr1}, 32'd0);

    repeat (3) @(posedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
